// File: rtl/exe_issue_ctrl_pkg.sv
// rtl/exe_issue_ctrl_pkg.sv - shared optype codes, FSM encoding and issue record for the execute sequencer
package exe_issue_ctrl_pkg;

    localparam int OPTYPE_W = 5;
    localparam int XLEN     = 32;

    // Decoded optype codes, common to decode, the execute datapath and this controller.
    localparam logic [OPTYPE_W-1:0] I_NOP  = 5'd0;
    localparam logic [OPTYPE_W-1:0] I_ADD  = 5'd1;
    localparam logic [OPTYPE_W-1:0] I_SUB  = 5'd2;
    localparam logic [OPTYPE_W-1:0] I_AND  = 5'd3;
    localparam logic [OPTYPE_W-1:0] I_OR   = 5'd4;
    localparam logic [OPTYPE_W-1:0] I_XOR  = 5'd5;
    localparam logic [OPTYPE_W-1:0] I_ADDI = 5'd6;
    localparam logic [OPTYPE_W-1:0] I_MUL  = 5'd7;
    localparam logic [OPTYPE_W-1:0] I_MULH = 5'd8;
    localparam logic [OPTYPE_W-1:0] I_LW   = 5'd9;
    localparam logic [OPTYPE_W-1:0] I_SW   = 5'd10;
    localparam logic [OPTYPE_W-1:0] I_BEQ  = 5'd11;
    localparam logic [OPTYPE_W-1:0] I_BNE  = 5'd12;
    localparam logic [OPTYPE_W-1:0] I_JAL  = 5'd13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MULW = 2'd2;
    localparam logic [1:0] ST_MEM  = 2'd3;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_MUL  = 3'd5,
        ALU_MULH = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic [OPTYPE_W-1:0] optype;
        logic [4:0]          rd;
        logic [XLEN-1:0]     data1;
        logic [XLEN-1:0]     data2;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     offset;
        logic [XLEN-1:0]     pc;
    } issue_t;

    function automatic logic is_mul_op(input logic [OPTYPE_W-1:0] optype);
        return (optype == I_MUL) || (optype == I_MULH);
    endfunction

endpackage

// File: rtl/exe_issue_ctrl.sv
// rtl/exe_issue_ctrl.sv - execute-stage issue register, multi-cycle MUL stretch, LW/SW handshake, wb/flush events
module exe_issue_ctrl
    import exe_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_optype,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_data1,
    input  logic [31:0] id_data2,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_offset,
    input  logic [31:0] id_pc,

    output logic [4:0]  ex_optype,
    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_offset,
    output logic [31:0] ex_pc,

    input  logic [31:0] dp_res,
    input  logic        dp_write_reg,
    input  logic        dp_load_en,
    input  logic        dp_store_en,
    input  logic        dp_jmp_en,
    input  logic [31:0] dp_jmp_addr,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,

    output logic        flush,
    output logic [31:0] redirect_addr,
    output logic        busy
);

    localparam bit               MUL_MULTI    = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [1:0]       state_q, state_d, state_adv;
    issue_t           issue_q, issue_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_q, redirect_d;

    logic             complete;
    logic             complete_wb;
    logic             complete_jmp;
    logic [31:0]      complete_data;
    logic             accept;

    // Completion decode: which state finishes the op this cycle and what it leaves behind.
    always_comb begin
        complete      = 1'b0;
        complete_wb   = 1'b0;
        complete_jmp  = 1'b0;
        complete_data = dp_res;
        state_adv     = state_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_EXEC: begin
                if (dp_jmp_en) begin
                    complete     = 1'b1;
                    complete_jmp = 1'b1;
                end else if (MUL_MULTI && is_mul_op(issue_q.optype)) begin
                    cnt_d     = MUL_CNT_INIT;
                    state_adv = ST_MULW;
                end else if (dp_load_en || dp_store_en) begin
                    state_adv = ST_MEM;
                end else begin
                    complete    = 1'b1;
                    complete_wb = dp_write_reg;
                end
            end
            ST_MULW: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    complete    = 1'b1;
                    complete_wb = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    complete      = 1'b1;
                    complete_wb   = dp_load_en;
                    complete_data = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // A redirect squashes whatever decode is presenting, so no accept while one is pending or pulsing.
    assign id_ready = ((state_q == ST_IDLE) || complete) && !complete_jmp && !flush_q;
    assign accept   = id_valid && id_ready;

    always_comb begin
        state_d = state_adv;
        if (accept) begin
            state_d = ST_EXEC;
        end else if (complete) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        issue_d = issue_q;
        if (accept) begin
            issue_d.optype = id_optype;
            issue_d.rd     = id_rd;
            issue_d.data1  = id_data1;
            issue_d.data2  = id_data2;
            issue_d.imm    = id_imm;
            issue_d.offset = id_offset;
            issue_d.pc     = id_pc;
        end
    end

    always_comb begin
        wb_valid_d = complete_wb;
        wb_rd_d    = complete_wb ? issue_q.rd : wb_rd_q;
        wb_data_d  = complete_wb ? complete_data : wb_data_q;
        flush_d    = complete_jmp;
        redirect_d = complete_jmp ? dp_jmp_addr : redirect_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            issue_q    <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign ex_optype = issue_q.optype;
    assign ex_data1  = issue_q.data1;
    assign ex_data2  = issue_q.data2;
    assign ex_imm    = issue_q.imm;
    assign ex_offset = issue_q.offset;
    assign ex_pc     = issue_q.pc;

    // Memory outputs are decoded from state so an asynchronous reset drops the request at once.
    assign mem_req   = (state_q == ST_MEM);
    assign mem_we    = mem_req && dp_store_en;
    assign mem_addr  = mem_req ? dp_res : '0;
    assign mem_wdata = issue_q.data1;

    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign flush         = flush_q;
    assign redirect_addr = redirect_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/exe_issue_ctrl.md
Name: exe_issue_ctrl

Overview:
- Execute-stage sequencer for the RISC-V core; sits between the decode stage and the combinational execute datapath.
- Holds the decoded instruction in an issue register and drives it into the execute datapath.
- Stretches multi-cycle MUL/MULH operations and runs the data-memory handshake for LW/SW.
- Produces registered writeback and branch-redirect/flush events, and back-pressures decode with a valid/ready handshake.

Parameters:
- MUL_LAT, 3, total execute cycles for MUL/MULH including the EXEC cycle; legal range 1..15.
- CNT_W, 4, width of the multi-cycle down-counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  controller accepts the instruction this cycle
- id_optype  in  5  decoded op code (`I_* encoding)
- id_rd  in  5  destination register index
- id_data1, id_data2, id_imm, id_offset, id_pc  in  32 each  operands, immediate, branch/memory offset, instruction address
- ex_optype  out  5  registered op code driven to the execute datapath
- ex_data1, ex_data2, ex_imm, ex_offset, ex_pc  out  32 each  registered operand copies driven to the execute datapath
- dp_res  in  32  datapath result or memory address
- dp_write_reg, dp_load_en, dp_store_en, dp_jmp_en  in  1 each  datapath decode flags
- dp_jmp_addr  in  32  branch/jump target
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  equals dp_res while mem_req is high
- mem_wdata  out  32  equals ex_data1
- mem_ack  in  1  memory completes the request
- mem_rdata  in  32  load data, valid with mem_ack
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register index
- wb_data  out  32  writeback data
- flush  out  1  one-cycle redirect pulse
- redirect_addr  out  32  new PC, valid with flush
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, all ex_* = 0, counter = 0. Outputs mem_req, wb_valid, flush and busy = 0; wb_rd, wb_data and redirect_addr = 0. Reset during MEM drops mem_req immediately, and the op is lost.
- States: IDLE, EXEC, MULW, MEM.
- Accept: the handshake occurs when id_valid & id_ready. On handshake, id_* are latched into ex_* and the next state is EXEC. ex_* are held stable until the next handshake.
- id_ready = (state==IDLE | completion this cycle) & !flush. It is 0 in any completion cycle that has dp_jmp_en=1.
- EXEC, one cycle:
  - dp_jmp_en=1: complete; set flush=1 and redirect_addr=dp_jmp_addr next cycle; no wb.
  - ex_optype is `I_MUL or `I_MULH with MUL_LAT>1: load counter=MUL_LAT-1 and go to MULW.
  - dp_load_en or dp_store_en: go to MEM.
  - Otherwise complete; if dp_write_reg, set wb_valid=1, wb_rd=ex_rd, wb_data=dp_res next cycle.
- MULW: counter decrements each cycle. The op completes in the cycle where counter==1; dp_res is written back next cycle.
- MEM:
  - mem_req=1, mem_we=dp_store_en, held until mem_ack. mem_ack is sampled only in MEM and ignored elsewhere.
  - On ack the op completes. A load sets wb_valid=1 with wb_data=mem_rdata and wb_rd=ex_rd next cycle; a store produces no wb.
- Completion without a new handshake returns to IDLE. Completion with a handshake in the same cycle goes straight to EXEC (back-to-back issue).
- Latency, for a handshake in cycle c:
  - EXEC is c+1.
  - Simple ALU op: wb_valid in c+2.
  - MUL/MULH: wb_valid in c+MUL_LAT+1.
  - Load: wb_valid in k+1, where k is the mem_ack cycle.
  - Taken branch/JAL: flush in c+2.
- Unknown optype (datapath flags all 0): completes in EXEC with no side effects.
- wb_valid and flush are never high together. Each is a single-cycle pulse.

Decomposition:
- Shared define/package holds:
  - the `I_* optype codes, already shared with decode and the execute datapath;
  - the state encoding (2 bits);
  - the ALU opcode constants: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 mul, 6 mulh.
- No sub-module; the counter and FSM are small enough to stay inline.

Test Plan:
- Reset mid-MEM: issue LW, hold mem_ack=0, pulse rst_n low -> mem_req falls asynchronously, busy=0, no wb after release.
- ADD data1=5, data2=7, rd=3, then ADDI on the next cycle -> wb_valid in c+2 with rd=3, data=12; second op accepted back-to-back with no bubble; id_ready stays 1.
- MUL 6*7, rd=4, MUL_LAT=3 -> id_ready=0 for 2 cycles; wb_valid at c+4 with data=42, rd=4; busy high for cycles c+1..c+3.
- LW addr=0x100, mem_ack delayed 3 cycles, mem_rdata=0xDEADBEEF:
  - mem_req high with mem_we=0 and mem_addr=0x100 until ack;
  - wb in the cycle after ack with that data.
- SW with ack in the first MEM cycle -> mem_we=1, mem_wdata=ex_data1, single-cycle req, no wb_valid.
- BEQ taken (data1=data2=9, offset target 0x40) with id_valid held high -> flush=1 with redirect_addr=0x40 in c+2; id_ready=0 in c+1 and c+2; following op not latched until c+3.
